// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional FETCH_BYPASS_EN lets a response skip the prefetch FIFO when it is empty.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One prefetch buffer entry: {pc, instr}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: small circular FIFO of {pc, instr} entries with a synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage array is deliberately not reset; pointers and count alone decide
  // which entries are valid, so the array can map onto plain flops or a RAM without reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: prefetches sequential words, buffers them, handles redirects/flushes.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     imem,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  fetch_state_e     state;
  logic [31:0]      pc;
  logic [31:0]      rsp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] out_after_drop;
  logic             started;
  logic             accept;
  logic             rsp_keep;
  logic             bypass;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     rsp_entry;
  fetch_entry_t     out_entry;

  assign accept         = imem.imem_req_valid & imem.imem_req_ready;
  assign out_after_drop = outstanding - CNT_W'(imem.imem_rsp_valid);
  assign rsp_keep       = imem.imem_rsp_valid && (state == RUN) && !redirect_valid;
  assign rsp_entry      = '{pc: rsp_pc, instr: imem.imem_rsp_data};

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_pop  = !fifo_empty && instr_ready && !redirect_valid;
  assign fifo_push = rsp_keep && !(bypass && instr_ready);

  // A slot freed by this cycle's pop is credited immediately; the new request cannot
  // respond before next cycle, so the buffer still cannot overflow and depth 2 streams.
  assign imem.imem_req_valid = started && (state == RUN) && !redirect_valid &&
      ((CNT_W+1)'(outstanding) + (CNT_W+1)'(fifo_count) <
       (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(fifo_pop));
  assign imem.imem_addr = pc;

  assign instr_valid = !fifo_empty || bypass;
  assign out_entry   = bypass ? rsp_entry : fifo_head;
  assign instr       = instr_valid ? out_entry.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? out_entry.pc : 32'h0;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (rsp_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // started keeps the request line low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_err   <= 1'b0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        pc          <= redirect_pc;
        rsp_pc      <= redirect_pc;
        outstanding <= out_after_drop;
        drop_cnt    <= out_after_drop;
        fetch_err   <= (redirect_pc[1:0] != 2'b00);
        if (out_after_drop != '0)          state <= FLUSH;
        else if (redirect_pc[1:0] != 2'b00) state <= HALT;
        else                                state <= RUN;
      end else begin
        if (accept) pc <= pc + 32'd4;
        outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem.imem_rsp_valid);
        case (state)
          RUN: if (rsp_keep) rsp_pc <= rsp_pc + 32'd4;
          FLUSH: begin
            if (imem.imem_rsp_valid) begin
              drop_cnt <= drop_cnt - 1'b1;
              if (drop_cnt == CNT_W'(1)) state <= fetch_err ? HALT : RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random memory/decoder/redirect traffic against a stream model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, instr_ready, redirect_valid, fetch_err;
  logic [31:0] redirect_pc;

  fetch_if bus();

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, delivered = 0, live = 0;
  int          rdy_pct = 100, ir_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] exp_pc, exp_req;
  logic        err_m = 1'b0, after_redirect = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_pc = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_idle();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    instr_ready        = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = 32'h0;
  endtask

  // Reference behaviour: after reset or a redirect to T, requests and deliveries both
  // follow T, T+4, ... ; a misaligned target halts everything until an aligned redirect.
  task automatic observe();
    if (!instr_valid) begin
      check("idle_instr", instr, NOP_INSTR);
      check("idle_pc", instr_pc, 32'h0);
    end
    if (after_redirect) check("flushed_empty", instr_valid, 1'b0);
    check("fetch_err", fetch_err, err_m);
    if (err_m) check("halt_no_instr", instr_valid, 1'b0);
    if (err_m || redirect_valid) check("no_request", bus.imem_req_valid, 1'b0);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("req_addr", bus.imem_addr, exp_req);
      pend.push_back('{addr: bus.imem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
      exp_req += 32'd4;
      live++;
    end
    if (bus.imem_rsp_valid) void'(pend.pop_front());
    if (!redirect_valid && instr_valid && instr_ready) begin
      check("dlv_pc", instr_pc, exp_pc);
      check("dlv_word", instr, mem_word(exp_pc));
      exp_pc += 32'd4;
      live--;
      delivered++;
    end
    check("live_bound", 32'(live <= DEPTH), 32'd1);
    if (redirect_valid) begin
      exp_pc  = redirect_pc;
      exp_req = redirect_pc;
      err_m   = (redirect_pc[1:0] != 2'b00);
      live    = 0;
    end
    after_redirect = redirect_valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    instr_ready        = ($urandom_range(99) < ir_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    redirect_valid = rd_req;
    redirect_pc    = rd_pc;
    rd_req         = 1'b0;
    @(negedge clk);
    observe();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    pend.delete();
    exp_pc = RPC;  exp_req = RPC;
    err_m = 1'b0;  after_redirect = 1'b0;
    live = 0;      rd_req = 1'b0;
    @(negedge clk);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, NOP_INSTR);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fetch_err", fetch_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    rd_req = 1'b1;
    rd_pc  = t;
    step();
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 200 == 0) begin
        rdy_pct = $urandom_range(100, 40);
        ir_pct  = $urandom_range(100, 30);
        lat_min = 1;
        lat_max = $urandom_range(4, 1);
      end
      if ($urandom_range(99) < 3) begin
        rd_req = 1'b1;
        case ($urandom_range(9))
          0:       rd_pc = $urandom | 32'h1;
          1:       rd_pc = 32'hFFFF_FFF4;
          default: rd_pc = $urandom & 32'hFFFF_FFFC;
        endcase
      end
      step();
    end
  endtask

  initial begin
    int d0;
    drive_idle();
    do_reset();

    // Full-rate streaming: starts at the reset PC, then one word per cycle.
    rdy_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;
    repeat (10) step();
    d0 = delivered;
    repeat (20) step();
    check("throughput", delivered - d0, 20);

    // Decoder stall: buffer fills to exactly its depth and nothing is lost.
    ir_pct = 0;
    repeat (5) step();
    check("stall_fill", live, DEPTH);
    ir_pct = 100;
    repeat (10) step();

    // Redirect with two requests outstanding behind a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    repeat (10) step();
    check("two_outstanding", pend.size(), 2);
    redirect_to(32'h0000_0100);
    repeat (12) step();
    check("resume_0x100", 32'(exp_pc > 32'h0000_0100), 32'd1);

    // Redirect in the same cycle as a response and a pop.
    lat_min = 1; lat_max = 1;
    repeat (10) step();
    redirect_to(32'h0000_0300);
    repeat (10) step();

    // Misaligned target halts; an aligned one clears the error and resumes.
    redirect_to(32'h0000_0102);
    repeat (8) step();
    check("halt_err", fetch_err, 1'b1);
    redirect_to(32'h0000_0200);
    repeat (10) step();
    check("halt_cleared", fetch_err, 1'b0);

    // Address wrap past 32'hFFFF_FFFC.
    redirect_to(32'hFFFF_FFF0);
    repeat (12) step();
    check("wrapped", 32'(exp_req < 32'h0000_0100), 32'd1);

    random_phase(1500);
    do_reset();
    random_phase(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
